// File: rtl/is_uart_rx_tx_bridge.sv
// UART stream bridge: filters errored rx characters, buffers clean bytes in a FIFO
// and hands them back to the TX side, optionally holding them until a full line is in.
module is_uart_rx_tx_bridge #(
  parameter int         DEPTH     = 16,
  parameter bit         LINE_MODE = 1'b0,
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rx_data_en_i,
  input  logic [9:0]               rx_data_t_i,
  input  logic                     tx_rdy_r_i,
  output logic                     tx_rdy_t_o,
  output logic [7:0]               tx_data_r_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [7:0]               err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, line_cnt_q, line_cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_rd_q, tx_data_q;
  logic [7:0]    err_cnt_q;
  logic          overflow_q;

  logic empty, full, gate, rx_bad, rx_clean, rx_wr, rd_issue, capture;
  logic line_inc, line_dec;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rx_bad   = rx_data_en_i && (rx_data_t_i[9:8] != 2'b00);
  assign rx_clean = rx_data_en_i && (rx_data_t_i[9:8] == 2'b00);
  assign rx_wr    = rx_clean && !full;

  // In line mode a full FIFO with no complete line forces release so it cannot deadlock.
  assign gate = LINE_MODE ? ((line_cnt_q != '0) || full) : !empty;

  assign line_inc = LINE_MODE && rx_wr && (rx_data_t_i[7:0] == TERM_CHAR);
  assign line_dec = LINE_MODE && capture && (mem_rd_q == TERM_CHAR);

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (line_inc && !line_dec)      line_cnt_d = line_cnt_q + 1'b1;
    else if (line_dec && !line_inc) line_cnt_d = line_cnt_q - 1'b1;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gate) begin
          rd_issue = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        capture = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (tx_rdy_r_i) begin
          if (gate) begin
            rd_issue = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      line_cnt_q <= '0;
      tx_data_q  <= 8'h00;
      err_cnt_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      if (rx_wr)    wr_ptr_q  <= wr_ptr_q + 1'b1;
      if (rd_issue) rd_ptr_q  <= rd_ptr_q + 1'b1;
      if (capture)  tx_data_q <= mem_rd_q;
      if (rx_bad && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 1'b1;
      if (rx_clean && full) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is left unreset; pointers define validity, and no reset keeps it RAM-mappable.
  always_ff @(posedge clk_i) begin
    if (rx_wr)    mem_q[wr_ptr_q[AW-1:0]] <= rx_data_t_i[7:0];
    if (rd_issue) mem_rd_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  assign tx_rdy_t_o  = (state_q == PRESENT);
  assign tx_data_r_o = tx_data_q;
  assign level_o     = wr_ptr_q - rd_ptr_q;
  assign overflow_o  = overflow_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_is_uart_rx_tx_bridge.sv
// Scoreboard bench: stimulus pushes expected bytes, per-instance monitors pop on each TX transfer.
module tb_is_uart_rx_tx_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       rx_en_a = 1'b0, rx_en_b = 1'b0;
  logic [9:0] rx_t_a = '0, rx_t_b = '0;
  logic       rdy_a = 1'b0, rdy_b = 1'b0;
  logic       rdy_t_a, rdy_t_b;
  logic [7:0] data_a, data_b;
  logic [4:0] level_a, level_b;
  logic       ovf_a, ovf_b;
  logic [7:0] err_a, err_b;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  always #5 clk = ~clk;

  is_uart_rx_tx_bridge #(.DEPTH(16), .LINE_MODE(1'b0), .TERM_CHAR(8'h0D)) u_a (
    .clk_i(clk), .rst_i(rst), .rx_data_en_i(rx_en_a), .rx_data_t_i(rx_t_a),
    .tx_rdy_r_i(rdy_a), .tx_rdy_t_o(rdy_t_a), .tx_data_r_o(data_a),
    .level_o(level_a), .overflow_o(ovf_a), .err_cnt_o(err_a));

  is_uart_rx_tx_bridge #(.DEPTH(16), .LINE_MODE(1'b1), .TERM_CHAR(8'h0D)) u_b (
    .clk_i(clk), .rst_i(rst), .rx_data_en_i(rx_en_b), .rx_data_t_i(rx_t_b),
    .tx_rdy_r_i(rdy_b), .tx_rdy_t_o(rdy_t_b), .tx_data_r_o(data_b),
    .level_o(level_b), .overflow_o(ovf_b), .err_cnt_o(err_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [9:0] v);
    rx_en_a = 1'b1; rx_t_a = v; tick(1); rx_en_a = 1'b0;
  endtask

  task automatic push_b(input logic [9:0] v);
    rx_en_b = 1'b1; rx_t_b = v; tick(1); rx_en_b = 1'b0;
  endtask

  task automatic wait_drain_a();
    logic done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_a.size() == 0 && level_a == 0 && !rdy_t_a) done = 1'b1;
      else tick(1);
    end
    check("drain_a", 32'(done), 32'd1);
  endtask

  task automatic wait_drain_b();
    logic done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_b.size() == 0 && level_b == 0 && !rdy_t_b) done = 1'b1;
      else tick(1);
    end
    check("drain_b", 32'(done), 32'd1);
  endtask

  // A transfer is a cycle with valid and ready both high; sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && rdy_t_a && rdy_a) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected: got %02h expected none", data_a);
      end else check("a_byte", 32'(data_a), 32'(exp_a.pop_front()));
    end
    if (!rst && rdy_t_b && rdy_b) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got %02h expected none", data_b);
      end else check("b_byte", 32'(data_b), 32'(exp_b.pop_front()));
    end
  end

  initial begin
    logic saw;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_rdy", 32'(rdy_t_a), 32'd0);
    check("rst_data", 32'(data_a), 32'h00);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Single byte: strobe in cycle 0, valid in cycle 3, gone in cycle 4
    rdy_a = 1'b1;
    exp_a.push_back(8'h41);
    push_a(10'h041);
    check("lat_c1", 32'(rdy_t_a), 32'd0);
    tick(1);
    check("lat_c2", 32'(rdy_t_a), 32'd0);
    tick(1);
    check("lat_c3_rdy", 32'(rdy_t_a), 32'd1);
    check("lat_c3_data", 32'(data_a), 32'h41);
    tick(1);
    check("lat_c4_rdy", 32'(rdy_t_a), 32'd0);
    wait_drain_a();
    check("single_level", 32'(level_a), 32'd0);

    // Backpressure: 8'h55 held while ready is low, then both drain in order
    rdy_a = 1'b0;
    exp_a.push_back(8'h55);
    exp_a.push_back(8'hAA);
    push_a(10'h055);
    push_a(10'h0AA);
    tick(3);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!rdy_t_a || data_a != 8'h55 || level_a != 5'd1) saw = 1'b1;
      tick(1);
    end
    check("bp_held_bad_cycles", 32'(saw), 32'd0);
    check("bp_data", 32'(data_a), 32'h55);
    check("bp_level", 32'(level_a), 32'd1);
    rdy_a = 1'b1;
    wait_drain_a();

    // Errored characters are counted, never forwarded
    push_a(10'h141);
    push_a(10'h242);
    push_a(10'h343);
    tick(5);
    check("err_cnt3", 32'(err_a), 32'd3);
    check("err_level", 32'(level_a), 32'd0);
    check("err_rdy", 32'(rdy_t_a), 32'd0);
    for (int i = 0; i < 300; i++) push_a(10'h100 | 10'(i[7:0]));
    tick(2);
    check("err_sat", 32'(err_a), 32'd255);
    check("err_ovf_clear", 32'(ovf_a), 32'd0);

    // Overflow: byte 0 moves to the output register one cycle after it lands,
    // so 1..16 fill all 16 entries and only byte 17 is dropped.
    rdy_a = 1'b0;
    for (int i = 0; i <= 16; i++) exp_a.push_back(8'(i));
    for (int i = 0; i < 18; i++) push_a(10'(i));
    tick(3);
    check("ovf_level", 32'(level_a), 32'd16);
    check("ovf_flag", 32'(ovf_a), 32'd1);
    check("ovf_head", 32'(data_a), 32'h00);
    rdy_a = 1'b1;
    wait_drain_a();
    check("ovf_sticky", 32'(ovf_a), 32'd1);

    // Line mode: nothing released until the terminator is buffered
    rdy_b = 1'b1;
    exp_b.push_back(8'h48);
    exp_b.push_back(8'h69);
    exp_b.push_back(8'h0D);
    push_b(10'h048);
    push_b(10'h069);
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rdy_t_b) saw = 1'b1;
      tick(1);
    end
    check("line_hold", 32'(saw), 32'd0);
    check("line_level", 32'(level_b), 32'd2);
    push_b(10'h00D);
    wait_drain_b();
    check("line_cnt_zero", 32'(u_b.line_cnt_q), 32'd0);

    // Line mode full without a terminator: exactly one byte is forced out
    exp_b.push_back(8'h10);
    for (int i = 0; i < 16; i++) push_b(10'h010 + 10'(i));
    tick(12);
    check("full_open_level", 32'(level_b), 32'd15);
    check("full_open_rdy", 32'(rdy_t_b), 32'd0);
    for (int i = 1; i < 16; i++) exp_b.push_back(8'h10 + 8'(i));
    exp_b.push_back(8'h0D);
    push_b(10'h00D);
    wait_drain_b();

    // Async reset while presenting 8'h41 with five bytes queued
    rdy_a = 1'b0;
    for (int i = 0; i < 6; i++) push_a(i == 0 ? 10'h041 : 10'(i));
    tick(2);
    check("pre_rst_rdy", 32'(rdy_t_a), 32'd1);
    check("pre_rst_data", 32'(data_a), 32'h41);
    check("pre_rst_level", 32'(level_a), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_rdy", 32'(rdy_t_a), 32'd0);
    check("arst_data", 32'(data_a), 32'h00);
    check("arst_level", 32'(level_a), 32'd0);
    check("arst_ovf", 32'(ovf_a), 32'd0);
    check("arst_err", 32'(err_a), 32'd0);
    tick(2);
    rst = 1'b0;
    rdy_a = 1'b1;
    tick(20);
    check("post_rst_rdy", 32'(rdy_t_a), 32'd0);
    check("post_rst_level", 32'(level_a), 32'd0);
    check("post_rst_queue", 32'(exp_a.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
